// File: rtl/dmux4way16_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_pkg
//  Purpose  : Shared widths and slot state type for the 4-way 16-bit stream
//             demultiplexer.
//  Contents : DATA_W, NUM_CH, SEL_W, CNT_W and the slot_state_t enum.
//  Config   : DMUX4WAY16_CNT_EN adds the per-channel counter outputs.
//             It is used by the design files; this package does not depend
//             on it.
//  Revision : 1.0 - initial release
// ============================================================================
package dmux_pkg;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage : dmux_pkg
`default_nettype wire

// File: rtl/dmux4way16_stream_slot.sv
`default_nettype none
// ============================================================================
//  Module   : dmux_slot
//  Purpose  : Single-entry output buffer for one demux channel.
//             - Loading always wins: the slot ends the cycle FULL with the
//               new word, even if it drained in the same cycle.
//             - Draining alone only clears valid. The data register keeps its
//               last value.
//  Ports    : clk, rst_n        clock, async active-low reset
//             load, load_data   write a new word into the slot
//             drain             consumer ready (ignored while EMPTY)
//             data, valid       slot contents / FULL flag
//             cnt               accepted-word counter
//                               (only with DMUX4WAY16_CNT_EN)
//  Config   : DMUX4WAY16_CNT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module dmux_slot
  import dmux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
`ifdef DMUX4WAY16_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);

  slot_state_t       r_state;
  slot_state_t       w_state_next;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: if (load) w_state_next = FULL;
      FULL: begin
        if (load) begin
          w_state_next = FULL;
        end else if (drain) begin
          w_state_next = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= load_data;
    end
  end

  assign data  = r_data;
  assign valid = (r_state == FULL);

`ifdef DMUX4WAY16_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // The counter wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
`endif

endmodule : dmux_slot
`default_nettype wire

// File: rtl/dmux4way16_stream.sv
`default_nettype none
// ============================================================================
//  Module   : dmux4way16_stream
//  Purpose  : Registered 4-way, 16-bit stream demultiplexer.
//             - Each word on the valid/ready input goes to the slot chosen
//               by in_sel.
//             - Each slot then presents it on its own valid/ready channel.
//  Ports    : clk, rst_n                  clock, async active-low reset
//             in_data/in_sel/in_valid     producer side
//             in_ready                    accept indication
//             o0..o3, o_valid             slot data / FULL flags
//             o_ready                     consumer ready per channel
//             cnt0..cnt3                  accepted-word counters
//                                         (only with DMUX4WAY16_CNT_EN)
//  Config   : DMUX4WAY16_CNT_EN
//  Revision : 1.0 - initial release
// ============================================================================
module dmux4way16_stream
  import dmux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3,
  output logic [NUM_CH-1:0] o_valid,
  input  logic [NUM_CH-1:0] o_ready
`ifdef DMUX4WAY16_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3
`endif
);

  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [DATA_W-1:0] w_slot_data [NUM_CH];
`ifdef DMUX4WAY16_CNT_EN
  logic [CNT_W-1:0]  w_slot_cnt  [NUM_CH];
`endif

  // Readiness depends only on the selected slot and its consumer, never on
  // in_valid. A draining slot can take a new word in the same cycle.
  assign in_ready = !o_valid[in_sel] | o_ready[in_sel];
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept ? (NUM_CH'(1) << in_sel) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    dmux_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[k]),
      .drain     (o_ready[k]),
      .load_data (in_data),
      .data      (w_slot_data[k]),
      .valid     (o_valid[k])
`ifdef DMUX4WAY16_CNT_EN
      ,
      .cnt       (w_slot_cnt[k])
`endif
    );
  end

  assign o0 = w_slot_data[0];
  assign o1 = w_slot_data[1];
  assign o2 = w_slot_data[2];
  assign o3 = w_slot_data[3];

`ifdef DMUX4WAY16_CNT_EN
  assign cnt0 = w_slot_cnt[0];
  assign cnt1 = w_slot_cnt[1];
  assign cnt2 = w_slot_cnt[2];
  assign cnt3 = w_slot_cnt[3];
`endif

endmodule : dmux4way16_stream
`default_nettype wire

// File: tb/tb_dmux4way16_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmux4way16_stream
//  Purpose  : Self-checking bench for dmux4way16_stream.
//             A per-channel reference model (valid flag, word and count)
//             is advanced once per clock.
//  Config   : DMUX4WAY16_CNT_EN enables the counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmux4way16_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o0, o1, o2, o3;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
`ifdef DMUX4WAY16_CNT_EN
  logic [7:0]  cnt0, cnt1, cnt2, cnt3;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: one single-entry buffer per channel.
  bit   [3:0]  mv;
  logic [15:0] md [4];
  int          mc [4];

  dmux4way16_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o_valid  (o_valid),
    .o_ready  (o_ready)
`ifdef DMUX4WAY16_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .cnt3     (cnt3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] dut_word(int k);
    case (k)
      0:       return o0;
      1:       return o1;
      2:       return o2;
      default: return o3;
    endcase
  endfunction

`ifdef DMUX4WAY16_CNT_EN
  function automatic logic [7:0] dut_cnt(int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      2:       return cnt2;
      default: return cnt3;
    endcase
  endfunction
`endif

  function automatic bit model_ready();
    return !mv[in_sel] || o_ready[in_sel];
  endfunction

  function automatic void model_clear();
    mv = '0;
    for (int k = 0; k < 4; k++) begin
      md[k] = '0;
      mc[k] = 0;
    end
  endfunction

  // Advance the model with the inputs presented this cycle, then let the
  // DUT clock once. Control returns at the next falling edge.
  task automatic tick();
    bit acc;
    acc = in_valid && model_ready();
    for (int k = 0; k < 4; k++) begin
      if (acc && (int'(in_sel) == k)) begin
        mv[k] = 1'b1;
        md[k] = in_data;
        mc[k] = (mc[k] + 1) % 256;
      end else if (mv[k] && o_ready[k]) begin
        mv[k] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] sel, input logic [15:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    o_ready  = '0;
    rst_n    = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (o_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b want 0000", o_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (dut_word(k) !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_data%0d: got %h want 0000", k, dut_word(k));
      end
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [15:0] words [4];
    words[0] = 16'h1000;
    words[1] = 16'h2000;
    words[2] = 16'h4000;
    words[3] = 16'h8000;
    o_ready  = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_sel   = 2'(k);
      in_data  = words[k];
      in_valid = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready%0d: got %b want 1", k, in_ready);
      end
      tick();
      tests_run++;
      if (o_valid !== (4'b0001 << k) || dut_word(k) !== words[k]) begin
        tests_failed++;
        $display("FAIL stream_word%0d: got valid %b data %h want valid %b data %h",
                 k, o_valid, dut_word(k), 4'b0001 << k, words[k]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    o_ready = 4'b1011;
    send(2'd2, 16'h4000);
    // Independence: channel 0 still accepts while channel 2 is stalled.
    in_sel   = 2'd0;
    in_data  = 16'h1234;
    in_valid = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (o0 !== 16'h1234 || o_valid[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL indep_o0: got %h/%b want 1234/1", o0, o_valid[0]);
    end
    // Offer a second word to the stalled channel and hold it stable.
    in_sel   = 2'd2;
    in_data  = 16'hAAAA;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_ready%0d: got %b want 0", i, in_ready);
      end
      tick();
      tests_run++;
      if (o2 !== 16'h4000 || o_valid[2] !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got %h/%b want 4000/1", i, o2, o_valid[2]);
      end
    end
    o_ready = 4'b1111;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (o2 !== 16'hAAAA || o_valid[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_nobubble: got %h/%b want AAAA/1", o2, o_valid[2]);
    end
    tick();
  endtask

  task automatic test_drain_load();
    o_ready = 4'b0000;
    send(2'd1, 16'h0001);
    o_ready = 4'b1111;
    send(2'd1, 16'h0002);
    tests_run++;
    if (o1 !== 16'h0002 || o_valid !== 4'b0010) begin
      tests_failed++;
      $display("FAIL drain_load: got %h/%b want 0002/0010", o1, o_valid);
    end
    tick();
  endtask

  task automatic test_all_drain_one_load();
    o_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send(2'(k), 16'(16'h0A00 + k));
    tests_run++;
    if (o_valid !== 4'b1111) begin
      tests_failed++;
      $display("FAIL fill_all: got %b want 1111", o_valid);
    end
    o_ready = 4'b1111;
    send(2'd2, 16'hBEEF);
    tests_run++;
    if (o_valid !== 4'b0100 || o2 !== 16'hBEEF || o0 !== 16'h0A00) begin
      tests_failed++;
      $display("FAIL all_drain_load: got %b o2 %h o0 %h want 0100 BEEF 0A00",
               o_valid, o2, o0);
    end
    tick();
  endtask

  task automatic test_random();
    bit stalled;
    stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      o_ready = 4'($urandom);
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom);
        in_data  = 16'($urandom);
      end
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++;
        $display("FAIL rnd_ready@%0d: got %b want %b", i, in_ready, model_ready());
      end
      stalled = in_valid && !model_ready();
      tick();
      tests_run++;
      if (o_valid !== mv) begin
        tests_failed++;
        $display("FAIL rnd_valid@%0d: got %b want %b", i, o_valid, mv);
      end
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (dut_word(k) !== md[k]) begin
          tests_failed++;
          $display("FAIL rnd_data%0d@%0d: got %h want %h", k, i, dut_word(k), md[k]);
        end
`ifdef DMUX4WAY16_CNT_EN
        tests_run++;
        if (dut_cnt(k) !== 8'(mc[k])) begin
          tests_failed++;
          $display("FAIL rnd_cnt%0d@%0d: got %h want %h", k, i, dut_cnt(k), 8'(mc[k]));
        end
`endif
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    o_ready = 4'b0000;
    for (int k = 0; k < 4; k++) send(2'(k), 16'(16'hC000 + k));
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (o_valid !== 4'b0000 || o3 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_reset: got %b o3 %h want 0000 0000", o_valid, o3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef DMUX4WAY16_CNT_EN
  task automatic test_counter_wrap();
    test_reset();
    o_ready  = 4'b1111;
    in_sel   = 2'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (cnt3 !== 8'h01 || cnt0 !== 8'h00) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got cnt3 %h cnt0 %h want 01 00", cnt3, cnt0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain_load();
    test_all_drain_one_load();
    test_random();
    test_reset_midstream();
`ifdef DMUX4WAY16_CNT_EN
    test_counter_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_dmux4way16_stream
`default_nettype wire
